// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the pipelined execute ALU.
// Opcode constants keep the original single-cycle ALU encodings (ADD..SW)
// and extend them upward; FSM state encodings are fixed at IDLE=0, MUL=1,
// HOLD=2 so that external checkers can decode dbg_state.
// Optional feature macro: ALU_OVF_EN (see alu_pipe.sv).
package alu_pipe_pkg;

  localparam int DSIZE_DEF = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_MUL  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SRL  = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Opcodes 13..15 are undefined.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier.
// Consumes MUL_STEP multiplier bits per cycle; a start pulse loads the
// operands and clears the accumulator, and 'done' is high during the final
// step, when 'product' already holds the finished result (accumulator plus
// the last partial product), so the caller can register it on that edge.
// With ALU_OVF_EN defined the accumulator is 2*DSIZE wide and the upper half
// of the full product is exported on product_hi; otherwise high product bits
// are discarded.
module alu_mul_iter #(
  parameter int DSIZE    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef ALU_OVF_EN
  output logic [DSIZE-1:0] product_hi,
`endif
  output logic [DSIZE-1:0] product
);

`ifdef ALU_OVF_EN
  localparam int ACC_W = 2 * DSIZE;
`else
  localparam int ACC_W = DSIZE;
`endif

  localparam int STEPS = DSIZE / MUL_STEP;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mcand;
  logic [DSIZE-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] partial;
  logic [ACC_W-1:0] acc_next;

  // Partial product for the low MUL_STEP bits of the remaining multiplier.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  assign acc_next = acc + partial;
  assign done     = busy && (cnt == LAST);
  assign product  = acc_next[DSIZE-1:0];
`ifdef ALU_OVF_EN
  assign product_hi = acc_next[ACC_W-1:DSIZE];
`endif

  // Engine registers: load on start, then one step per cycle until done.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= ACC_W'(a);
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked EX-stage ALU.
// Single-cycle ops are registered one cycle after acceptance; MUL runs on
// alu_mul_iter for DSIZE/MUL_STEP cycles. out, zero and illegal are always
// written together from the same operation, so zero is never stale.
// Optional feature macro: ALU_OVF_EN adds the registered 'ovf' output.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high, on the input side (in_valid/in_ready) and on the output side
// (out_valid/out_ready) alike. While out_valid && !out_ready the presented
// result (out, zero, illegal, ovf) does not change. in_ready is a function
// of state and out_ready only; it never depends on in_valid.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DSIZE    = DSIZE_DEF,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       instr_code,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [DSIZE-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic             zero,
  output logic             illegal,
  output logic             busy,
`ifdef ALU_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(DSIZE);

  state_t state, state_next;

  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [DSIZE-1:0] mul_prod;
  logic [DSIZE-1:0] add_ab;
  logic [DSIZE-1:0] add_ai;
  logic [DSIZE-1:0] sub_ab;
  logic [DSIZE-1:0] alu_res;
  logic             alu_illegal;
`ifdef ALU_OVF_EN
  logic [DSIZE-1:0] mul_prod_hi;
  logic             alu_ovf;
`endif

  assign is_mul    = (instr_code == OP_MUL);
  assign in_ready  = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;
  assign dbg_state = state;

  assign add_ab = a + b;
  assign add_ai = a + imm;
  assign sub_ab = a - b;

  alu_mul_iter #(
    .DSIZE    (DSIZE),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start      (mul_start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (mul_done),
`ifdef ALU_OVF_EN
    .product_hi (mul_prod_hi),
`endif
    .product    (mul_prod)
  );

  // Single-cycle operation mux; undefined opcodes yield 0 and flag illegal.
  always_comb begin
    alu_res     = '0;
    alu_illegal = !op_is_legal(instr_code);
    case (instr_code)
      OP_ADD:                  alu_res = add_ab;
      OP_ADDI, OP_LW, OP_SW:   alu_res = add_ai;
      OP_BNE, OP_SUB:          alu_res = sub_ab;
      OP_AND:                  alu_res = a & b;
      OP_OR:                   alu_res = a | b;
      OP_XOR:                  alu_res = a ^ b;
      OP_SLL:                  alu_res = a << b[SHW-1:0];
      OP_SRL:                  alu_res = a >> b[SHW-1:0];
      OP_SLT:                  alu_res = ($signed(a) < $signed(b)) ? DSIZE'(1) : '0;
      default:                 alu_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  // Signed overflow of the add/subtract ops; all other single-cycle ops 0.
  always_comb begin
    alu_ovf = 1'b0;
    case (instr_code)
      OP_ADD:
        alu_ovf = (a[DSIZE-1] == b[DSIZE-1]) && (add_ab[DSIZE-1] != a[DSIZE-1]);
      OP_ADDI, OP_LW, OP_SW:
        alu_ovf = (a[DSIZE-1] == imm[DSIZE-1]) && (add_ai[DSIZE-1] != a[DSIZE-1]);
      OP_BNE, OP_SUB:
        alu_ovf = (a[DSIZE-1] != b[DSIZE-1]) && (sub_ab[DSIZE-1] != a[DSIZE-1]);
      default:
        alu_ovf = 1'b0;
    endcase
  end
`endif

  // Output register: a new completion wins over consumption, so a result
  // taken on the same edge as a new accept is replaced rather than dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (accept && !is_mul) begin
      out       <= alu_res;
      zero      <= (alu_res == '0);
      illegal   <= alu_illegal;
      out_valid <= 1'b1;
`ifdef ALU_OVF_EN
      ovf       <= alu_ovf;
`endif
    end else if (mul_done) begin
      out       <= mul_prod;
      zero      <= (mul_prod == '0);
      illegal   <= 1'b0;
      out_valid <= 1'b1;
`ifdef ALU_OVF_EN
      ovf       <= |mul_prod_hi;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state: MUL while the engine runs, HOLD while a result stalls.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mul_start)                    state_next = ST_MUL;
        else if (out_valid && !out_ready) state_next = ST_HOLD;
      end
      ST_MUL: begin
        if (mul_done) state_next = ST_IDLE;
      end
      ST_HOLD: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against a
// behavioural reference model, with a decoupled scoreboard monitor.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int MS = 1;
  localparam int EW = W + 3;

  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    instr_code;
  logic [W-1:0]  a, b, imm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          zero;
  logic          illegal;
  logic          busy;
  logic          dut_ovf;
  logic [1:0]    dbg_state;

`ifndef ALU_OVF_EN
  assign dut_ovf = 1'b0;
`endif

  alu_pipe #(.DSIZE(W), .MUL_STEP(MS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr_code (instr_code),
    .a          (a),
    .b          (b),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .zero       (zero),
    .illegal    (illegal),
    .busy       (busy),
`ifdef ALU_OVF_EN
    .ovf        (dut_ovf),
`endif
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 1;  // 0 random, 1 always ready, 2 stalled

  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {ovf, illegal, zero, out} from the opcode table in plain arithmetic.
  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] im);
    longint sx, sy, si, s;
    longint unsigned full;
    logic [W-1:0] r;
    logic v, ill;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    si = longint'($signed(im));
    sh = int'(y % W);
    r = '0; v = 1'b0; ill = 1'b0;
    case (op)
      4'd0:             begin s = sx + sy; r = W'(s); v = (s > SMAX) || (s < SMIN); end
      4'd1:             begin full = longint'(x) * longint'(y); r = full[W-1:0]; v = (full >> W) != 0; end
      4'd2, 4'd3, 4'd4: begin s = sx + si; r = W'(s); v = (s > SMAX) || (s < SMIN); end
      4'd5, 4'd6:       begin s = sx - sy; r = W'(s); v = (s > SMAX) || (s < SMIN); end
      4'd7:             r = x & y;
      4'd8:             r = x | y;
      4'd9:             r = x ^ y;
      4'd10:            r = x << sh;
      4'd11:            r = x >> sh;
      4'd12:            r = (sx < sy) ? W'(1) : W'(0);
      default:          ill = 1'b1;
    endcase
`ifndef ALU_OVF_EN
    v = 1'b0;
`endif
    return {v, ill, (r == '0), r};
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] im);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1; instr_code = op; a = x; b = y; imm = im;
    #2;
    while (!in_ready) begin
      guard++;
      if (guard > 300) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", guard);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #2;
    end
    exp_q.push_back(model(op, x, y, im));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Single-cycle op with always-ready consumer: result visible right after accept.
  task automatic issue_check(input string name, input logic [3:0] op, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] eo,
                             input logic ez, input logic ei);
    issue(op, x, y, '0);
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check({name, "_out"}, 64'(out), 64'(eo));
    check({name, "_zero"}, 64'(zero), 64'(ez));
    check({name, "_illegal"}, 64'(illegal), 64'(ei));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [EW-1:0] got, expv, held;
    bit held_v;
    held_v = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      #2;
      if (rst) begin
        held_v = 0;
      end else begin
        got = {dut_ovf, illegal, zero, out};
        if (held_v) check("hold_stable", 64'({out_valid, got}), 64'({1'b1, held}));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: got out=%0h with no pending operation", out);
          end else begin
            expv = exp_q.pop_front();
            check("scoreboard", 64'(got), 64'(expv));
          end
          held_v = 0;
        end else if (out_valid) begin
          held_v = 1; held = got;
        end else begin
          held_v = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int bcnt, g, seen;
    logic [3:0] op;
    logic [W-1:0] x, y;
    in_valid = 1'b0; instr_code = '0; a = '0; b = '0; imm = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out", 64'(out), 64'(0));
    check("rst_zero", 64'(zero), 64'(0));
    check("rst_illegal", 64'(illegal), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    check("rst_ovf", 64'(dut_ovf), 64'(0));
    @(negedge clk) rst = 1'b0;

    ready_mode = 1;
    issue_check("add_5_7", 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    issue_check("bne_9_9", 4'd5, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
    issue_check("add_1_1", 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    issue_check("slt_neg", 4'd12, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    issue_check("sll_mask", 4'd10, 32'd1, 32'h21, 32'd2, 1'b0, 1'b0);
    issue_check("illegal_14", 4'd14, 32'h1234, 32'h5678, 32'd0, 1'b1, 1'b1);

    // Multiplier: busy/in_ready window, latency and product.
    issue(4'd1, 32'h0001_0003, 32'h0000_0005, '0);
    bcnt = 0; g = 0;
    while (busy && !in_ready && g < 200) begin
      bcnt++; @(posedge clk); #1; g++;
    end
    check("mul_busy_cycles", 64'(bcnt), 64'(W / MS));
    check("mul_done_valid", 64'(out_valid), 64'(1));
    check("mul_out", 64'(out), 64'(32'h0005_000F));
`ifdef ALU_OVF_EN
    check("mul_ovf0", 64'(dut_ovf), 64'(0));
`endif
    issue(4'd1, 32'h8000_0000, 32'h8000_0000, '0);
    g = 0;
    while (!out_valid && g < 200) begin @(posedge clk); #1; g++; end
    check("mul_big_out", 64'(out), 64'(0));
    check("mul_big_zero", 64'(zero), 64'(1));
`ifdef ALU_OVF_EN
    check("mul_big_ovf", 64'(dut_ovf), 64'(1));
`endif

    // Back-pressure: result held, no new accept, then release.
    repeat (3) @(posedge clk);
    ready_mode = 2;
    issue(4'd6, 32'd3, 32'd5, '0);
    repeat (4) begin
      @(negedge clk); #2;
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out", 64'(out), 64'(32'hFFFF_FFFE));
    end
    ready_mode = 1;
    issue(4'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, '0);

    // Reset during a multiply aborts it.
    repeat (3) @(posedge clk);
    issue(4'd1, 32'd7, 32'd9, '0);
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_out", 64'(out), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk); #2;
      if (out_valid) seen++;
    end
    check("abort_no_output", 64'(seen), 64'(0));
    issue_check("add_2_2", 4'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);

    // Randomized phase with random back-pressure.
    ready_mode = 0;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        x = W'($urandom_range(0, 8)); y = W'($urandom_range(0, 8));
      end else begin
        x = $urandom; y = $urandom;
      end
      issue(op, x, y, $urandom);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    ready_mode = 1;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin @(posedge clk); g++; end
    check("drain_queue", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU; sits in the EX stage between decode/register-read and memory/writeback.
- Single-cycle ops return one cycle after acceptance.
- MUL runs on an iterative shift-add engine whose cycle count is set by a parameter.
- The result register and zero flag always describe the same operation; zero is never one result stale.

Parameters:
- DSIZE, 32, operand/result width. Must be ≥ 8 and a power of 2.
- MUL_STEP, 1, multiplier bits consumed per cycle. Must divide DSIZE; MUL latency is DSIZE/MUL_STEP cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept this cycle
- instr_code  in  4  opcode
- a  in  DSIZE  operand 1
- b  in  DSIZE  operand 2
- imm  in  DSIZE  sign-extended immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out  out  DSIZE  result
- zero  out  1  out == 0
- illegal  out  1  accepted opcode was undefined
- busy  out  1  multiplier engine active

Behaviour:
- Reset: one clock, synchronous, active-high. While rst=1 at a rising edge: state=IDLE, out=0, zero=0, out_valid=0, illegal=0, busy=0, in_ready=0.
- Reset mid-multiply aborts the operation; no result is produced.
- Opcodes:
  - ADD=0: a+b
  - MUL=1: low DSIZE bits of a*b, unsigned
  - ADDI=2, LW=3, SW=4: a+imm
  - BNE=5: a-b
  - SUB=6: a-b
  - AND=7, OR=8, XOR=9: bitwise a op b
  - SLL=10, SRL=11: shift a by b[log2(DSIZE)-1:0]
  - SLT=12: signed a<b gives 1, else 0
  - 13-15: illegal
- All arithmetic wraps modulo 2^DSIZE. No carry out.
- Acceptance: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full rate.
- FSM states: IDLE, MUL, HOLD.
  - IDLE, accept non-MUL: next edge loads out, zero and illegal, sets out_valid=1. Latency 1.
  - IDLE, accept MUL: latch a and b, clear accumulator, busy=1, step counter=0, go to MUL.
  - MUL: each cycle add the partial product for MUL_STEP bits of b, shift, counter++. On the final step, write out/zero, out_valid=1, busy=0, go to IDLE.
  - HOLD: entered when out_valid=1, out_ready=0 and no accept is possible. Exits to IDLE on out_ready.
- Output stability: out, zero and illegal are stable while out_valid && !out_ready.
- out_valid clears on out_ready when there is no new completion in the same cycle.
- Illegal opcode: out=0, zero=1, illegal=1, one-cycle latency, handshake as normal.
- in_valid while busy is ignored (in_ready=0). Inputs are not sampled.
- Simultaneous out_ready and a new accept: the old result is consumed and the new result is written at the same edge.
- MUL latency from accept edge to out_valid: DSIZE/MUL_STEP cycles. For example, 32 at defaults, 8 with MUL_STEP=4.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: extra output port ovf (1 bit), registered with out, reset 0.
  - ADD/ADDI/LW/SW: signed overflow of the addition.
  - SUB/BNE: signed overflow of the subtraction.
  - MUL: any nonzero bit above DSIZE in the full product, so the engine keeps a 2*DSIZE accumulator.
  - All other ops: 0.
- Undefined: no ovf port. Accumulator is DSIZE wide; high product bits are discarded.

Decomposition:
- Shared define header:
  - opcode constants (ADD..SLT), extending the existing encodings without renumbering
  - DSIZE default
  - FSM state encodings IDLE=0, MUL=1, HOLD=2
- One sub-module, alu_mul_iter: iterative multiplier with start/done, parameters DSIZE and MUL_STEP.
- Top level holds the combinational op mux, output register, handshake and FSM.

Test Plan:
- Reset then ADD a=5, b=7, out_ready=1: out_valid one cycle after accept, out=12, zero=0.
- BNE a=9, b=9: out=0, zero=1 in the same cycle as out_valid. Then ADD 1+1: out=2, zero=0. Checks zero is not stale.
- MUL a=0x0001_0003, b=0x0000_0005, DSIZE=32, MUL_STEP=1:
  - busy=1 and in_ready=0 for 32 cycles
  - out=0x0005_000F
  - with ALU_OVF_EN, ovf=0
  - repeat with a=b=0x8000_0000: out=0; with ALU_OVF_EN, ovf=1.
- Back-pressure: issue SUB 3-5 with out_ready=0 for 4 cycles. out=0xFFFF_FFFE held stable, in_ready=0. Release: next op accepted in the same cycle.
- SLT a=0xFFFF_FFFF, b=1 gives out=1. SLL a=1, b=0x21 gives out=2 (shift amount masked to 1). Opcode 14 gives illegal=1, out=0, zero=1.
- Assert rst mid-MUL (cycle 10). No out_valid follows, all outputs return to reset values, and the next ADD 2+2 returns 4.
